// File: rtl/psram_spi_ctrl.sv
// psram_spi_ctrl: CPU strobe bus to 1-bit SPI PSRAM bridge.
// One bus access becomes one CE-framed mode-0 transaction.
module psram_spi_ctrl #(
  parameter int ADDR_WIDTH = 23,
  parameter int CLK_DIV    = 2,
  parameter int FAST_READ  = 1,
  parameter int CE_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rstrb,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wmask,
  output logic [31:0]           mem_rdata,
  output logic                  mem_rbusy,
  output logic                  mem_wbusy,
  output logic                  ram_ce_n,
  output logic                  ram_sclk,
  output logic                  ram_mosi,
  input  logic                  ram_miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [4:0] DIV_LO = 5'(CLK_DIV - 1);
  localparam logic [4:0] DIV_HI = 5'(2 * CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(CE_GAP - 1);
  localparam logic [7:0] RD_CMD =
    (FAST_READ != 0) ? 8'h0B : 8'h03;
  localparam logic [7:0] WR_CMD = 8'h02;

  logic [2:0]  state;
  logic [4:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic [63:0] tx_sr;
  logic [30:0] rx_sr;
  logic        is_wr;
  logic [5:0]  data_last;

  logic        wr_req;
  logic        rd_req;
  logic [1:0]  lo;
  logic [1:0]  hi;
  logic [2:0]  nbytes;
  logic [31:0] wsh;
  logic [31:0] wpack;
  logic [23:0] req_addr;
  logic [63:0] tx_load;
  logic [31:0] rx_next;
  logic        unused_ok;

  // Request decode: lane span, start address, shift image.
  always_comb begin
    wr_req = |mem_wmask;
    rd_req = mem_rstrb & ~wr_req;
    if (mem_wmask[0])      lo = 2'd0;
    else if (mem_wmask[1]) lo = 2'd1;
    else if (mem_wmask[2]) lo = 2'd2;
    else                   lo = 2'd3;
    if (mem_wmask[3])      hi = 2'd3;
    else if (mem_wmask[2]) hi = 2'd2;
    else if (mem_wmask[1]) hi = 2'd1;
    else                   hi = 2'd0;
    nbytes = {1'b0, hi} - {1'b0, lo} + 3'd1;
    wsh = mem_wdata >> {lo, 3'b000};
    wpack = {wsh[7:0], wsh[15:8],
             wsh[23:16], wsh[31:24]};
    req_addr = '0;
    req_addr[ADDR_WIDTH-1:0] =
      {mem_addr[ADDR_WIDTH-1:2],
       wr_req ? lo : 2'b00};
    tx_load = wr_req
      ? {WR_CMD, req_addr, wpack}
      : {RD_CMD, req_addr, 32'h0};
    rx_next = {rx_sr, ram_miso};
    unused_ok = &{1'b0, mem_addr[1:0]};
  end

  assign ram_mosi = tx_sr[63];

  // Sequencer: SPI bit timing, phase walk, busy flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      is_wr     <= 1'b0;
      data_last <= '0;
      mem_rdata <= '0;
      mem_rbusy <= 1'b0;
      mem_wbusy <= 1'b0;
      ram_ce_n  <= 1'b1;
      ram_sclk  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (wr_req || rd_req) begin
            state     <= S_CMD;
            ram_ce_n  <= 1'b0;
            ram_sclk  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= 6'd7;
            tx_sr     <= tx_load;
            is_wr     <= wr_req;
            data_last <= wr_req
              ? {nbytes, 3'b000} - 6'd1
              : 6'd31;
            mem_wbusy <= wr_req;
            mem_rbusy <= rd_req;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state     <= S_IDLE;
            mem_rbusy <= 1'b0;
            mem_wbusy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          if (div_cnt == DIV_LO) begin
            ram_sclk <= 1'b1;
            div_cnt  <= div_cnt + 5'd1;
            if (state == S_DATA && !is_wr) begin
              rx_sr <= rx_next[30:0];
              if (bit_cnt == 6'd0)
                mem_rdata <= {rx_next[7:0],
                              rx_next[15:8],
                              rx_next[23:16],
                              rx_next[31:24]};
            end
          end else if (div_cnt == DIV_HI) begin
            ram_sclk <= 1'b0;
            div_cnt  <= '0;
            tx_sr    <= {tx_sr[62:0], 1'b0};
            if (bit_cnt != 6'd0) begin
              bit_cnt <= bit_cnt - 6'd1;
            end else begin
              unique case (state)
                S_CMD: begin
                  state   <= S_ADDR;
                  bit_cnt <= 6'd23;
                end
                S_ADDR: begin
                  if (!is_wr && FAST_READ != 0) begin
                    state   <= S_DUMMY;
                    bit_cnt <= 6'd7;
                  end else begin
                    state   <= S_DATA;
                    bit_cnt <= data_last;
                  end
                end
                S_DUMMY: begin
                  state   <= S_DATA;
                  bit_cnt <= data_last;
                end
                default: begin
                  state    <= S_GAP;
                  ram_ce_n <= 1'b1;
                  gap_cnt  <= '0;
                  tx_sr    <= '0;
                end
              endcase
            end
          end else begin
            div_cnt <= div_cnt + 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/psram_spi_ctrl.md
Name: psram_spi_ctrl

Overview:
Bridges the CPU's single-cycle-strobe memory bus to an external serial PSRAM over a 1-bit SPI link (mode 0, MSB first). It turns one bus read or write into a complete CE-framed transaction and stretches the CPU access with busy flags. It sits in the SOC beside the internal RAM and is selected by its own address decode.

Parameters:
ADDR_WIDTH, 23, byte-address width; sent zero-extended to 24 bits.
CLK_DIV, 2, clk cycles per SCLK half-period; legal values 1..15.
FAST_READ, 1, 1 = command 0x0B with 8 dummy clocks; 0 = command 0x03 with no dummy.
CE_GAP, 2, minimum clk cycles CE_n stays high between transactions; legal values 1..15.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
mem_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored (word-aligned)
mem_rstrb  in  1  one-cycle read request
mem_wdata  in  32  write data, little-endian lanes
mem_wmask  in  4  byte-lane write enables; non-zero = write request
mem_rdata  out  32  read data, held until the next read completes
mem_rbusy  out  1  read in progress
mem_wbusy  out  1  write in progress
ram_ce_n  out  1  PSRAM chip enable, active low
ram_sclk  out  1  SPI clock, idles low
ram_mosi  out  1  serial data to PSRAM
ram_miso  in  1  serial data from PSRAM

Behaviour:
- Reset (async, resetn=0): ram_ce_n=1, ram_sclk=0, ram_mosi=0, mem_rbusy=0, mem_wbusy=0, mem_rdata=0, state=IDLE. Reset mid-transaction aborts the transaction immediately; no partial result is retained.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> [DUMMY (8 clocks), reads with FAST_READ=1 only] -> DATA -> GAP -> IDLE.
- Requests are sampled only in IDLE. Requests arriving in any other state are ignored. The CPU must wait for busy to clear.
- A request with mem_wmask!=0 and mem_rstrb=1 in the same cycle is treated as a write. The read is dropped and mem_rbusy is not raised.
- Acceptance edge: the busy flag for that transaction goes to 1, ram_ce_n goes to 0, and the command, address and data are latched. The CPU may change the bus inputs afterwards.
- Bit timing: each SPI bit lasts 2*CLK_DIV clk cycles. ram_sclk is low for the first CLK_DIV cycles and high for the second CLK_DIV cycles.
  - ram_mosi changes only while ram_sclk is low.
  - ram_miso is sampled on the clk edge at which ram_sclk rises.
- Read transaction:
  - Command is 0x03 or 0x0B, followed by the address {word address, 2'b00}.
  - 32 data bits follow. The first byte received goes to mem_rdata[7:0], the fourth byte to mem_rdata[31:24].
  - mem_rdata updates on the edge at which the last bit is sampled.
- Write transaction:
  - Command is 0x02.
  - Start address = word address + index of the lowest set mask bit.
  - Bytes are sent from the lowest set lane through the highest set lane, so n = hi-lo+1 bytes.
  - Non-contiguous masks (e.g. 0101) also write the intermediate lanes with mem_wdata contents; the SOC issues only 0001/0010/0100/1000/0011/1100/1111.
  - mem_rdata is unchanged by writes.
- End of transaction:
  - After the final bit's high half, ram_sclk returns low, ram_ce_n goes to 1 and ram_mosi goes to 0.
  - GAP holds for CE_GAP cycles, then busy clears and the state returns to IDLE.
- Busy duration = total_bits*2*CLK_DIV + CE_GAP cycles, counted from the acceptance edge.
  - Reads: total_bits = 64 + 8*FAST_READ.
  - Writes: total_bits = 32 + 8n.
- Only one busy flag is high at a time. Bit and byte counters have no wrap; addresses at the top of the 24-bit space are passed through unmodified, and the PSRAM's wrap rule applies.

Test Plan:
1. CLK_DIV=1, FAST_READ=0. Model holds 0x44,0x33,0x22,0x11 at 0x000100. Issue a read with mem_addr=0x000102 -> MOSI carries 0x03, 0x000100; mem_rdata=0x11223344; mem_rbusy is high for exactly 130 cycles with CE_GAP=2.
2. FAST_READ=1, CLK_DIV=2 -> exactly 8 SCLK pulses between the address and the first sampled data bit; busy is high for 72*4+2 = 290 cycles.
3. Write with mem_wmask=0100, mem_wdata=0xAABBCCDD, addr 0x000200 -> MOSI carries 0x02, 0x000202, 0xBB; only one data byte is sent; mem_wbusy is high for 40*2*CLK_DIV+CE_GAP cycles; the model changes only byte 0x000202.
4. mem_wmask=1111 and mem_rstrb=1 asserted in the same cycle -> a 4-byte write is sent in the order DD,CC,BB,AA; mem_rbusy stays 0.
5. resetn pulsed low in the middle of the ADDR phase -> ram_ce_n=1, ram_sclk=0 and busy=0 with no clock edge needed; the next read completes normally.
6. Back-to-back reads, with the second issued the cycle busy falls -> ram_ce_n is high for at least CE_GAP cycles between transactions. A request issued while busy is ignored: no third transaction occurs.
